unpacked_array_loader: RTL and testbench

// - Parametrised register array of DEPTH entries x WIDTH bits, presented as an unpacked array output.
// - Supports four load modes: broadcast, indexed write, shift-in, and multi-cycle sweep.
// - Uses a valid/ready handshake with a small FSM; the sweep writes one entry per cycle.
// - Serves as a generic configuration/lane-fill store feeding downstream per-lane logic.

---
 rtl/unpacked_array_loader.sv | 116 +++++++++++
 tb/tb_unpacked_array_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/unpacked_array_loader.sv
// unpacked_array_loader: DEPTH x WIDTH register array with broadcast / indexed / shift / sweep loads.
// Optional feature macro UARR_PARITY_EN adds a per-entry even-parity output o_par.
`default_nettype none

module unpacked_array_loader #(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH > 1 ? DEPTH : 2)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_mode,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_arr [DEPTH],
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
`ifdef UARR_PARITY_EN
  ,
  output logic             o_par [DEPTH]
`endif
);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  localparam logic [1:0] MODE_BCAST = 2'b00;
  localparam logic [1:0] MODE_INDEX = 2'b01;
  localparam logic [1:0] MODE_SHIFT = 2'b10;
  localparam logic [1:0] MODE_SWEEP = 2'b11;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] remaining;
  logic [WIDTH-1:0] sweep_data;
  logic             idx_oob;

  assign o_ready = (state == IDLE);
  assign o_busy  = (state == SWEEP);
  // Index field can encode values past the last entry when DEPTH is not a power of two.
  assign idx_oob = (32'(i_idx) >= DEPTH);

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < DEPTH; k++) o_arr[k] <= '0;
      state      <= IDLE;
      ptr        <= '0;
      remaining  <= '0;
      sweep_data <= '0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid) begin
            unique case (i_mode)
              MODE_BCAST: begin
                for (int k = 0; k < DEPTH; k++) o_arr[k] <= i_data;
              end
              MODE_INDEX: begin
                if (idx_oob) o_err <= 1'b1;
                else         o_arr[i_idx] <= i_data;
              end
              MODE_SHIFT: begin
                o_arr[0] <= i_data;
                for (int k = 1; k < DEPTH; k++) o_arr[k] <= o_arr[k-1];
              end
              MODE_SWEEP: begin
                if (idx_oob) begin
                  o_err <= 1'b1;
                end else begin
                  // First write lands on the accept edge; the rest follow from SWEEP.
                  o_arr[i_idx] <= i_data;
                  sweep_data   <= i_data;
                  ptr          <= next_idx(i_idx);
                  remaining    <= IDX_W'(DEPTH - 1);
                  if (DEPTH == 1) o_done <= 1'b1;
                  else            state  <= SWEEP;
                end
              end
            endcase
          end
        end
        SWEEP: begin
          o_arr[ptr] <= sweep_data;
          ptr        <= next_idx(ptr);
          remaining  <= remaining - 1'b1;
          if (remaining == IDX_W'(1)) begin
            state  <= IDLE;
            o_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UARR_PARITY_EN
  for (genvar k = 0; k < DEPTH; k++) begin : g_par
    assign o_par[k] = ^o_arr[k];
  end
`else
  // Parity outputs are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_unpacked_array_loader.sv
// Bench: a DEPTH=8 and a DEPTH=6 loader share one input stream and are checked every cycle
// against a queue-based reference model, plus a directed table and corner-case sequences.
`default_nettype none

module tb_unpacked_array_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [2:0] idx = 3'd0;
  logic [3:0] data = 4'd0;

  logic       ready8, busy8, done8, err8;
  logic       ready6, busy6, done6, err6;
  logic [3:0] arr8 [8];
  logic [3:0] arr6 [6];
`ifdef UARR_PARITY_EN
  logic       par8 [8];
  logic       par6 [6];
`endif

  always #5 clk = ~clk;

  unpacked_array_loader #(.WIDTH(4), .DEPTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready8), .i_mode(mode),
    .i_idx(idx), .i_data(data), .o_arr(arr8), .o_busy(busy8), .o_done(done8), .o_err(err8)
`ifdef UARR_PARITY_EN
    , .o_par(par8)
`endif
  );

  unpacked_array_loader #(.WIDTH(4), .DEPTH(6)) dut6 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready6), .i_mode(mode),
    .i_idx(idx), .i_data(data), .o_arr(arr6), .o_busy(busy6), .o_done(done6), .o_err(err6)
`ifdef UARR_PARITY_EN
    , .o_par(par6)
`endif
  );

  // Reference model: array contents plus a queue of pending sweep write indices.
  logic [3:0] m_arr [2][8];
  int         pend [2][$];
  logic [3:0] m_sd [2];
  bit         m_done [2];
  bit         m_err [2];

  int n_vec = 0;
  int n_mis = 0;
  bit cnt_en = 1'b0;
  int low_cnt = 0;
  int done_cnt = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [2:0]  idx;
    logic [3:0]  data;
    logic [31:0] exp;   // expected {e7,...,e0} of the DEPTH=8 array
  } vec_t;
  vec_t tbl [8];

  function automatic int depth_of(input int d);
    return (d == 0) ? 8 : 6;
  endfunction

  function automatic logic [3:0] act_arr(input int d, input int k);
    return (d == 0) ? arr8[k] : arr6[k];
  endfunction

  function automatic logic [31:0] pack8();
    return {arr8[7], arr8[6], arr8[5], arr8[4], arr8[3], arr8[2], arr8[1], arr8[0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit r;
    for (int d = 0; d < 2; d++) begin
      r = (pend[d].size() == 0);
      check($sformatf("d%0d.ready", depth_of(d)), (d == 0) ? ready8 : ready6, r);
      check($sformatf("d%0d.busy", depth_of(d)), (d == 0) ? busy8 : busy6, !r);
      check($sformatf("d%0d.done", depth_of(d)), (d == 0) ? done8 : done6, m_done[d]);
      check($sformatf("d%0d.err", depth_of(d)), (d == 0) ? err8 : err6, m_err[d]);
      for (int k = 0; k < depth_of(d); k++) begin
        check($sformatf("d%0d.arr[%0d]", depth_of(d), k), act_arr(d, k), m_arr[d][k]);
`ifdef UARR_PARITY_EN
        check($sformatf("d%0d.par[%0d]", depth_of(d), k),
              (d == 0) ? par8[k] : par6[k], ^m_arr[d][k]);
`endif
      end
    end
    if (cnt_en) begin
      if (!ready8) low_cnt++;
      if (done8) done_cnt++;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 8; k++) m_arr[d][k] = 4'd0;
      pend[d].delete();
      m_sd[d]   = 4'd0;
      m_done[d] = 1'b0;
      m_err[d]  = 1'b0;
    end
  endtask

  task automatic model_step(input int d);
    int dep;
    int p;
    dep = depth_of(d);
    m_done[d] = 1'b0;
    m_err[d]  = 1'b0;
    if (pend[d].size() != 0) begin
      p = pend[d].pop_front();
      m_arr[d][p] = m_sd[d];
      if (pend[d].size() == 0) m_done[d] = 1'b1;
    end else if (valid) begin
      case (mode)
        2'd0: for (int k = 0; k < dep; k++) m_arr[d][k] = data;
        2'd1: if (int'(idx) >= dep) m_err[d] = 1'b1; else m_arr[d][idx] = data;
        2'd2: begin
          for (int k = dep - 1; k > 0; k--) m_arr[d][k] = m_arr[d][k-1];
          m_arr[d][0] = data;
        end
        default: begin
          if (int'(idx) >= dep) m_err[d] = 1'b1;
          else begin
            m_arr[d][idx] = data;
            m_sd[d] = data;
            for (int j = 1; j < dep; j++) pend[d].push_back((int'(idx) + j) % dep);
          end
        end
      endcase
    end
  endtask

  // One clock: check the state left by the previous edge, then drive the next command.
  task automatic cycle(input bit v, input logic [1:0] m, input logic [2:0] i, input logic [3:0] dt);
    @(negedge clk);
    compare_all();
    valid = v;
    mode  = m;
    idx   = i;
    data  = dt;
    model_step(0);
    model_step(1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    valid = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int guard;
    tbl[0] = '{2'd0, 3'd0, 4'hA, 32'hAAAA_AAAA};
    tbl[1] = '{2'd1, 3'd3, 4'h5, 32'hAAAA_5AAA};
    tbl[2] = '{2'd2, 3'd0, 4'h1, 32'hAAA5_AAA1};
    tbl[3] = '{2'd2, 3'd5, 4'h2, 32'hAA5A_AA12};
    tbl[4] = '{2'd2, 3'd7, 4'h3, 32'hA5AA_A123};
    tbl[5] = '{2'd3, 3'd6, 4'hF, 32'hFFFF_FFFF};
    tbl[6] = '{2'd1, 3'd0, 4'h0, 32'hFFFF_FFF0};
    tbl[7] = '{2'd0, 3'd2, 4'h0, 32'h0000_0000};

    model_reset();
    do_reset();

    for (int t = 0; t < 8; t++) begin
      cycle(1'b1, tbl[t].mode, tbl[t].idx, tbl[t].data);
      guard = 0;
      while (pend[0].size() != 0 && guard < 20) begin
        cycle(1'b0, 2'd0, 3'd0, 4'd0);
        guard++;
      end
      if (guard >= 20) check("table_wait_timeout", 32'd1, 32'd0);
      cycle(1'b0, 2'd0, 3'd0, 4'd0);
      check($sformatf("table[%0d]", t), pack8(), tbl[t].exp);
    end

    // Out-of-range index on the DEPTH=6 instance.
    cycle(1'b1, 2'd1, 3'd7, 4'h9);
    cycle(1'b0, 2'd0, 3'd0, 4'd0);
    check("d6.err_pulse", err6, 32'd1);
    cycle(1'b0, 2'd0, 3'd0, 4'd0);
    check("d6.err_clear", err6, 32'd0);

    // Sweep from 6 with valid held high while busy.
    cycle(1'b1, 2'd0, 3'd0, 4'h0);
    cycle(1'b1, 2'd3, 3'd6, 4'hF);
    low_cnt  = 0;
    done_cnt = 0;
    cnt_en   = 1'b1;
    repeat (6) cycle(1'b1, 2'd0, 3'd0, 4'h0);
    repeat (3) cycle(1'b0, 2'd0, 3'd0, 4'h0);
    cnt_en = 1'b0;
    check("sweep_ready_low_cycles", low_cnt, 32'd7);
    check("sweep_done_pulses", done_cnt, 32'd1);
    check("sweep_final_array", pack8(), 32'hFFFF_FFFF);

    // Reset asserted on the third sweep cycle.
    cycle(1'b1, 2'd3, 3'd2, 4'h7);
    cycle(1'b0, 2'd0, 3'd0, 4'h0);
    cycle(1'b0, 2'd0, 3'd0, 4'h0);
    do_reset();
    repeat (4) cycle(1'b0, 2'd0, 3'd0, 4'h0);

    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
    end
    repeat (10) cycle(1'b0, 2'd0, 3'd0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
